// File: rtl/dtc_pkg.sv
// Shared types and helpers for the multi-channel digital-to-time converter.
package dtc_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GUARD} state_t;

   localparam logic MODE_EDGE  = 1'b0;
   localparam logic MODE_WIDTH = 1'b1;

   function automatic int code_max(input int n_bit);
      return (1 << n_bit) - 1;
   endfunction

   function automatic int frame_cycles(input int n_bit, input int t_unit, input int guard);
      return (1 << n_bit) * t_unit + guard + 1;
   endfunction
endpackage

// File: rtl/dtc_channel.sv
// One DTC lane: holds its code and registers the tick comparison onto its output.
module dtc_channel
   import dtc_pkg::*;
#(
   parameter int N_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             upd,
   input  logic             clr,
   input  logic             mode,
   input  logic [N_BIT-1:0] code_in,
   input  logic [N_BIT-1:0] tick_nx,
   output logic             out
);
   logic [N_BIT-1:0] code_q, code_sel;
   logic             hit;

   // On the load edge the fresh code drives tick 0 so out is valid from A+1.
   always_comb begin
      code_sel = load ? code_in : code_q;
      hit      = (mode == MODE_EDGE) ? (tick_nx >= code_sel) : (tick_nx < code_sel);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q <= '0;
         out    <= 1'b0;
      end else begin
         if (load) code_q <= code_in;
         if (clr)      out <= 1'b0;
         else if (upd) out <= hit;
      end
   end
endmodule

// File: rtl/dtc_multi_ch.sv
// Multi-channel DTC: frame FSM, prescaler, tick counter and handshake around N_CH lanes.
module dtc_multi_ch
   import dtc_pkg::*;
#(
   parameter int N_BIT  = 4,
   parameter int N_CH   = 4,
   parameter int T_UNIT = 1,
   parameter int GUARD  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_CH*N_BIT-1:0] in_data,
   input  logic                  in_mode,
   output logic [N_CH-1:0]       out,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int PW = $clog2(T_UNIT) + 1;
   localparam int GW = $clog2(GUARD + 1) + 1;
   localparam logic [N_BIT-1:0] TMAX  = N_BIT'(code_max(N_BIT));
   localparam logic [PW-1:0]    PLAST = PW'(T_UNIT - 1);
   localparam logic [GW-1:0]    GLAST = GW'((GUARD == 0) ? 0 : GUARD - 1);

   state_t           state;
   logic [N_BIT-1:0] tick, tick_nx;
   logic [PW-1:0]    pre, pre_nx;
   logic [GW-1:0]    gcnt;
   logic             mode_q, mode_sel;
   logic             accept, wrap, last_run, run_end_nx, upd;

   assign in_ready = !rst && (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      wrap       = (state == ST_RUN) && (pre == PLAST);
      last_run   = wrap && (tick == TMAX);
      tick_nx    = wrap ? tick + N_BIT'(1) : tick;
      pre_nx     = wrap ? '0 : pre + PW'(1);
      // true when the coming cycle is the final RUN cycle
      run_end_nx = (state == ST_RUN) && !last_run && (tick_nx == TMAX) && (pre_nx == PLAST);
      upd        = accept || (wrap && !last_run);
      mode_sel   = accept ? in_mode : mode_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         tick       <= '0;
         pre        <= '0;
         gcnt       <= '0;
         mode_q     <= MODE_EDGE;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               mode_q <= in_mode;
               tick   <= '0;
               pre    <= '0;
               state  <= ST_RUN;
            end
            ST_RUN: begin
               pre  <= pre_nx;
               tick <= tick_nx;
               if (last_run) begin
                  gcnt       <= '0;
                  state      <= (GUARD == 0) ? ST_IDLE : ST_GUARD;
                  frame_done <= (GUARD == 1);
               end else begin
                  frame_done <= (GUARD == 0) && run_end_nx;
               end
            end
            ST_GUARD: begin
               gcnt       <= gcnt + GW'(1);
               frame_done <= (gcnt + GW'(1) == GLAST);
               if (gcnt == GLAST) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      dtc_channel #(.N_BIT(N_BIT)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .load    (accept),
         .upd     (upd),
         .clr     (last_run),
         .mode    (mode_sel),
         .code_in (in_data[i*N_BIT +: N_BIT]),
         .tick_nx (tick_nx),
         .out     (out[i])
      );
   end
endmodule

// File: tb/tb_dtc_multi_ch.sv
// Directed bench for dtc_multi_ch: default build plus T_UNIT=4 builds with GUARD=1 and GUARD=0.
module tb_dtc_multi_ch;
   import dtc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic [15:0] din = '0;
   logic        md = 1'b0;
   logic        r0, r1, r2, b0, b1, b2, fd0, fd1, fd2;
   logic [3:0]  o0, o1, o2;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dtc_multi_ch u0 (.clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(din),
                    .in_mode(md), .out(o0), .busy(b0), .frame_done(fd0));
   dtc_multi_ch #(.T_UNIT(4), .GUARD(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
                    .in_data(din), .in_mode(md), .out(o1), .busy(b1), .frame_done(fd1));
   dtc_multi_ch #(.T_UNIT(4), .GUARD(0)) u2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
                    .in_data(din), .in_mode(md), .out(o2), .busy(b2), .frame_done(fd2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a frame on u0; returns in cycle A+1.
   task automatic start(input logic [15:0] d, input logic m);
      din = d;
      md  = m;
      chk("ready_before_start", r0, 1'b1);
      v0 = 1'b1;
      step();
      v0 = 1'b0;
   endtask

   // Called in cycle A+1 of a default-parameter frame; returns in cycle A+18.
   task automatic check_frame(input logic [15:0] d, input logic m, input string nm);
      logic [3:0] ev;
      for (int k = 1; k <= 18; k++) begin
         for (int i = 0; i < 4; i++) begin
            int c;
            c = int'(d[i*4 +: 4]);
            ev[i] = (k <= 16) && (m ? (k - 1 < c) : (k - 1 >= c));
         end
         chk($sformatf("%s out k=%0d", nm, k), o0, ev);
         chk($sformatf("%s frame_done k=%0d", nm, k), fd0, (k == 17));
         chk($sformatf("%s busy k=%0d", nm, k), b0, (k <= 17));
         chk($sformatf("%s in_ready k=%0d", nm, k), r0, (k == 18));
         if (k < 18) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // reset held for two cycles
      step();
      step();
      chk("rst out", o0, 4'b0);
      chk("rst busy", b0, 1'b0);
      chk("rst in_ready", r0, 1'b0);
      chk("rst frame_done", fd0, 1'b0);
      rst = 1'b0;
      #1;
      chk("post-rst in_ready", r0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("post-rst frame_done", fd0, 1'b0);
      end

      // edge-delay, codes {0,1,5,15}
      start(16'hF510, MODE_EDGE);
      check_frame(16'hF510, MODE_EDGE, "s2");
      step();

      // pulse-width, codes {0,3,8,15}
      start(16'hF830, MODE_WIDTH);
      check_frame(16'hF830, MODE_WIDTH, "s3");
      step();

      // T_UNIT=4, edge mode, ch0 code 2 on both guard variants
      din = 16'h0002;
      md  = MODE_EDGE;
      v1  = 1'b1;
      v2  = 1'b1;
      step();
      v1 = 1'b0;
      v2 = 1'b0;
      for (int k = 1; k <= frame_cycles(4, 4, 1); k++) begin
         chk($sformatf("s4 g1 out0 k=%0d", k), o1[0], (k >= 9 && k <= 64));
         chk($sformatf("s4 g0 out0 k=%0d", k), o2[0], (k >= 9 && k <= 64));
         chk($sformatf("s4 g1 frame_done k=%0d", k), fd1, (k == 65));
         chk($sformatf("s4 g0 frame_done k=%0d", k), fd2, (k == 64));
         chk($sformatf("s4 g0 in_ready k=%0d", k), r2, (k >= 65));
         chk($sformatf("s4 g1 in_ready k=%0d", k), r1, (k == 66));
         if (k < frame_cycles(4, 4, 1)) step();
      end
      step();

      // new data offered during busy must not disturb the running frame
      din = 16'h7531;
      md  = MODE_EDGE;
      v0  = 1'b1;
      step();
      din = 16'h2A4C;
      md  = MODE_WIDTH;
      check_frame(16'h7531, MODE_EDGE, "s5a");
      step();
      v0 = 1'b0;
      check_frame(16'h2A4C, MODE_WIDTH, "s5b");
      step();

      // asynchronous reset in the middle of cycle A+5
      start(16'hF510, MODE_EDGE);
      for (int k = 0; k < 4; k++) step();
      chk("s6 pre-abort out", o0, 4'b0011);
      #4;
      rst = 1'b1;
      #1;
      chk("s6 abort out", o0, 4'b0);
      chk("s6 abort busy", b0, 1'b0);
      chk("s6 abort frame_done", fd0, 1'b0);
      chk("s6 abort in_ready", r0, 1'b0);
      step();
      rst = 1'b0;
      #1;
      chk("s6 release in_ready", r0, 1'b1);
      chk("s6 release out", o0, 4'b0);
      for (int k = 0; k < 20; k++) begin
         chk("s6 no frame_done", fd0, 1'b0);
         step();
      end
      start(16'hF510, MODE_EDGE);
      check_frame(16'hF510, MODE_EDGE, "s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
